// File: rtl/ext_code_loader_if.sv
// ext_code_loader_if: groups the host byte link and the external-code table strobe bus.
//   iRxData/iRxValid/oRxReady : host byte stream with valid/ready handshake
//   oSET_INDEX_FLAG/oSET_INDEX : index strobe and value to the table
//   oSET_CODE_FLAG/oSET_CODE   : code strobe and 32-bit value to the table
//   oTrigger                   : playback trigger to the table
// Modport master is the loader's view, slave is the environment (host + table) view.
interface ext_code_loader_if;
    logic [7:0]  iRxData;
    logic        iRxValid;
    logic        oRxReady;
    logic        oSET_INDEX_FLAG;
    logic [7:0]  oSET_INDEX;
    logic        oSET_CODE_FLAG;
    logic [31:0] oSET_CODE;
    logic        oTrigger;

    modport master (
        input  iRxData, iRxValid,
        output oRxReady, oSET_INDEX_FLAG, oSET_INDEX, oSET_CODE_FLAG, oSET_CODE, oTrigger
    );

    modport slave (
        output iRxData, iRxValid,
        input  oRxReady, oSET_INDEX_FLAG, oSET_INDEX, oSET_CODE_FLAG, oSET_CODE, oTrigger
    );
endinterface

// File: rtl/ext_code_loader.sv
// ext_code_loader: parses a byte command stream (IDX / WRITE / FIRE / CLRERR) and generates
// the index strobe, code strobe and trigger pulse trains for the 8-slot external-code table.
//   iClk, iRst   : clock, synchronous active-high reset
//   bus          : ext_code_loader_if.master (byte link in, table strobes out)
//   oBusy        : sequence in progress
//   oErr         : sticky unknown-opcode flag, cleared by CLRERR
//   oShadowIndex : model of the table's current index
module ext_code_loader #(
    parameter int unsigned PULSE_W   = 4,
    parameter int unsigned GAP_W     = 4,
    parameter int unsigned TRIG_HIGH = 8,
    parameter int unsigned TRIG_LOW  = 8
) (
    input  logic                     iClk,
    input  logic                     iRst,
    ext_code_loader_if.master        bus,
    output logic                     oBusy,
    output logic                     oErr,
    output logic [7:0]               oShadowIndex
);

    // Timed states count down from width-1 to 0.
    localparam logic [7:0] PulseLd = 8'(PULSE_W - 1);
    localparam logic [7:0] GapLd   = 8'(GAP_W - 1);
    localparam logic [7:0] TrigHLd = 8'(TRIG_HIGH - 1);
    localparam logic [7:0] TrigLLd = 8'(TRIG_LOW - 1);

    localparam logic [1:0] OpIdx   = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;
    localparam logic [1:0] OpFire  = 2'd3;

    typedef enum logic [3:0] {
        StIdle, StArgs, StSetup, StIdxHi, StIdxGap, StCodeHi, StCodeGap, StTrigHi, StTrigLo
    } state_e;

    state_e      st_q, st_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  argn_q, argn_d;
    logic [7:0]  pend_idx_q, pend_idx_d;
    logic [23:0] code_sh_q, code_sh_d;
    logic [7:0]  idx_out_q, idx_out_d;
    logic [31:0] code_out_q, code_out_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  rep_q, rep_d;
    logic        err_q, err_d;
    logic [7:0]  shadow_q, shadow_d;
    logic        idx_flag_q, idx_flag_d;
    logic        code_flag_q, code_flag_d;
    logic        trig_q, trig_d;

    logic rx_open, rx_ready, accept, last_arg;

    assign rx_open  = (st_q == StIdle) || (st_q == StArgs);
    assign rx_ready = ~iRst & rx_open;
    assign accept   = bus.iRxValid & rx_ready;
    assign last_arg = ((op_q == OpIdx)   && (argn_q == 3'd0)) ||
                      ((op_q == OpWrite) && (argn_q == 3'd4)) ||
                      ((op_q == OpFire)  && (argn_q == 3'd1));

    always_comb begin
        st_d       = st_q;
        op_d       = op_q;
        argn_d     = argn_q;
        pend_idx_d = pend_idx_q;
        code_sh_d  = code_sh_q;
        idx_out_d  = idx_out_q;
        code_out_d = code_out_q;
        cnt_d      = cnt_q;
        rep_d      = rep_q;
        err_d      = err_q;
        shadow_d   = shadow_q;

        unique case (st_q)
            StIdle: begin
                if (accept) begin
                    unique case (bus.iRxData)
                        8'h01, 8'h02, 8'h03: begin
                            op_d   = bus.iRxData[1:0];
                            argn_d = 3'd0;
                            st_d   = StArgs;
                        end
                        8'h04:   err_d = 1'b0;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StArgs: begin
                if (accept) begin
                    argn_d = argn_q + 3'd1;
                    if (argn_q == 3'd0) pend_idx_d = bus.iRxData;
                    // The idx byte shifts through too; it falls out by the last code byte.
                    code_sh_d = {code_sh_q[15:0], bus.iRxData};
                    if (last_arg) begin
                        idx_out_d = (argn_q == 3'd0) ? bus.iRxData : pend_idx_q;
                        if (op_q == OpWrite) code_out_d = {code_sh_q, bus.iRxData};
                        rep_d = bus.iRxData;
                        st_d  = StSetup;
                    end
                end
            end
            StSetup: begin
                st_d  = StIdxHi;
                cnt_d = PulseLd;
            end
            StIdxHi: begin
                if (cnt_q == 8'd0) begin
                    st_d     = StIdxGap;
                    cnt_d    = GapLd;
                    shadow_d = idx_out_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StIdxGap: begin
                if (cnt_q == 8'd0) begin
                    if (op_q == OpWrite) begin
                        st_d  = StCodeHi;
                        cnt_d = PulseLd;
                    end else if ((op_q == OpFire) && (rep_q != 8'd0)) begin
                        st_d  = StTrigHi;
                        cnt_d = TrigHLd;
                    end else begin
                        st_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StCodeHi: begin
                if (cnt_q == 8'd0) begin
                    st_d  = StCodeGap;
                    cnt_d = GapLd;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StCodeGap: begin
                if (cnt_q == 8'd0) st_d = StIdle;
                else cnt_d = cnt_q - 8'd1;
            end
            StTrigHi: begin
                if (cnt_q == 8'd0) begin
                    st_d     = StTrigLo;
                    cnt_d    = TrigLLd;
                    shadow_d = shadow_q - 8'd1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StTrigLo: begin
                if (cnt_q == 8'd0) begin
                    rep_d = rep_q - 8'd1;
                    if (rep_q == 8'd1) begin
                        st_d = StIdle;
                    end else begin
                        st_d  = StTrigHi;
                        cnt_d = TrigHLd;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: st_d = StIdle;
        endcase

        // Strobes are registered copies of the next state, so they track it exactly.
        idx_flag_d  = (st_d == StIdxHi);
        code_flag_d = (st_d == StCodeHi);
        trig_d      = (st_d == StTrigHi);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            st_q        <= StIdle;
            op_q        <= 2'd0;
            argn_q      <= 3'd0;
            pend_idx_q  <= 8'd0;
            code_sh_q   <= 24'd0;
            idx_out_q   <= 8'd0;
            code_out_q  <= 32'd0;
            cnt_q       <= 8'd0;
            rep_q       <= 8'd0;
            err_q       <= 1'b0;
            shadow_q    <= 8'd0;
            idx_flag_q  <= 1'b0;
            code_flag_q <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            op_q        <= op_d;
            argn_q      <= argn_d;
            pend_idx_q  <= pend_idx_d;
            code_sh_q   <= code_sh_d;
            idx_out_q   <= idx_out_d;
            code_out_q  <= code_out_d;
            cnt_q       <= cnt_d;
            rep_q       <= rep_d;
            err_q       <= err_d;
            shadow_q    <= shadow_d;
            idx_flag_q  <= idx_flag_d;
            code_flag_q <= code_flag_d;
            trig_q      <= trig_d;
        end
    end

    assign bus.oRxReady        = rx_ready;
    assign bus.oSET_INDEX_FLAG = idx_flag_q;
    assign bus.oSET_INDEX      = idx_out_q;
    assign bus.oSET_CODE_FLAG  = code_flag_q;
    assign bus.oSET_CODE       = code_out_q;
    assign bus.oTrigger        = trig_q;
    assign oBusy               = ~iRst & ~rx_open;
    assign oErr                = err_q;
    assign oShadowIndex        = shadow_q;

endmodule

// File: tb/tb_ext_code_loader.sv
// Bench for ext_code_loader: table of commands with expected busy length, error flag and
// final shadow index; a scoreboard queue of expected strobe events checked as each strobe
// falls; hand-written sequences for back-pressure and mid-sequence reset.
module tb_ext_code_loader;
    localparam int unsigned PULSE_W   = 4;
    localparam int unsigned GAP_W     = 4;
    localparam int unsigned TRIG_HIGH = 8;
    localparam int unsigned TRIG_LOW  = 8;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       oBusy, oErr;
    logic [7:0] oShadowIndex;

    ext_code_loader_if bus ();

    ext_code_loader #(
        .PULSE_W  (PULSE_W),
        .GAP_W    (GAP_W),
        .TRIG_HIGH(TRIG_HIGH),
        .TRIG_LOW (TRIG_LOW)
    ) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .bus         (bus),
        .oBusy       (oBusy),
        .oErr        (oErr),
        .oShadowIndex(oShadowIndex)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [5:0][7:0] b;
        int unsigned     n;
        int unsigned     busy;
        logic            err;
        logic [7:0]      shadow;
        logic            jitter;
    } vec_t;

    typedef struct {
        int          kind;  // 0 index pulse, 1 code pulse, 2 trigger
        logic [31:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  trig_falls = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic got_event(input int kind, input logic [31:0] data, input int width);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe actual=kind%0d required=none", kind);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_data", data, e.val);
            check("ev_width", width, (kind == 2) ? TRIG_HIGH : PULSE_W);
            if (kind == 0) check("shadow_on_idx_fall", {24'd0, oShadowIndex}, e.val);
        end
    endtask

    // Strobe monitor: measures pulse widths and checks each pulse on its falling edge.
    initial begin
        logic pi, pc, pt;
        int   wi, wc, wt;
        pi = 0; pc = 0; pt = 0; wi = 0; wc = 0; wt = 0;
        forever begin
            @(negedge iClk);
            if (iRst) begin
                pi = 0; pc = 0; pt = 0; wi = 0; wc = 0; wt = 0;
            end else begin
                if (bus.oSET_INDEX_FLAG | bus.oSET_CODE_FLAG | bus.oTrigger)
                    check("one_hot", $countones({bus.oSET_INDEX_FLAG, bus.oSET_CODE_FLAG,
                                                 bus.oTrigger}), 1);
                if (bus.oSET_INDEX_FLAG) wi++;
                else if (pi) begin got_event(0, {24'd0, bus.oSET_INDEX}, wi); wi = 0; end
                if (bus.oSET_CODE_FLAG) wc++;
                else if (pc) begin got_event(1, bus.oSET_CODE, wc); wc = 0; end
                if (bus.oTrigger) wt++;
                else if (pt) begin
                    got_event(2, {24'd0, oShadowIndex}, wt);
                    wt = 0;
                    trig_falls++;
                end
                pi = bus.oSET_INDEX_FLAG;
                pc = bus.oSET_CODE_FLAG;
                pt = bus.oTrigger;
            end
        end
    end

    // Expected strobe events for a complete command.
    task automatic push_model(input vec_t v);
        logic [7:0] sh;
        ev_t        e;
        if (v.b[0] inside {8'h01, 8'h02, 8'h03}) begin
            e.kind = 0; e.val = {24'd0, v.b[1]}; exp_q.push_back(e);
            if (v.b[0] == 8'h02) begin
                e.kind = 1; e.val = {v.b[2], v.b[3], v.b[4], v.b[5]}; exp_q.push_back(e);
            end
            if (v.b[0] == 8'h03) begin
                sh = v.b[1];
                for (int k = 0; k < int'(v.b[2]); k++) begin
                    sh = sh - 8'd1;
                    e.kind = 2; e.val = {24'd0, sh}; exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit jitter, output int waits);
        waits = 0;
        if (jitter) begin
            repeat ($urandom_range(0, 2)) begin
                bus.iRxValid = 1'b0;
                bus.iRxData  = 8'($urandom);
                @(posedge iClk); #1;
            end
        end
        bus.iRxData  = b;
        bus.iRxValid = 1'b1;
        while (!bus.oRxReady && waits < 5000) begin
            @(posedge iClk); #1;
            waits++;
        end
        if (!bus.oRxReady) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout actual=0 required=1");
        end
        @(posedge iClk); #1;
        bus.iRxValid = 1'b0;
    endtask

    // Called #1 after the edge accepting the final byte; ends at a negedge with oBusy low.
    task automatic finish_cmd(input string nm, input vec_t v);
        int cnt;
        if (v.b[0] inside {8'h01, 8'h02, 8'h03}) begin
            check({nm, "_setup_idx"}, {24'd0, bus.oSET_INDEX}, {24'd0, v.b[1]});
            check({nm, "_setup_flag"}, {31'd0, bus.oSET_INDEX_FLAG}, 0);
            if (v.b[0] == 8'h02)
                check({nm, "_setup_code"}, bus.oSET_CODE, {v.b[2], v.b[3], v.b[4], v.b[5]});
        end
        cnt = 0;
        forever begin
            @(negedge iClk);
            if (!oBusy || cnt > 2000) break;
            cnt++;
        end
        check({nm, "_busy"}, cnt, v.busy);
        check({nm, "_ready"}, {31'd0, bus.oRxReady}, 1);
        check({nm, "_err"}, {31'd0, oErr}, {31'd0, v.err});
        check({nm, "_shadow"}, {24'd0, oShadowIndex}, {24'd0, v.shadow});
        check({nm, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int w;
        push_model(v);
        for (int i = 0; i < int'(v.n); i++) send_byte(v.b[i], v.jitter && (i > 0), w);
        finish_cmd(nm, v);
    endtask

    function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, b4, b5, input int unsigned n,
                                input int unsigned busy, input logic err, input logic [7:0] sh,
                                input logic jit);
        vec_t v;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4; v.b[5] = b5;
        v.n = n; v.busy = busy; v.err = err; v.shadow = sh; v.jitter = jit;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vec_t v;
        int   w, base, lim;

        vecs[0] = mk(8'h02, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 6, 17, 1'b0, 8'h05, 1'b1);
        vecs[1] = mk(8'h03, 8'h07, 8'h03, 8'h00, 8'h00, 8'h00, 3, 57, 1'b0, 8'h04, 1'b0);
        vecs[2] = mk(8'h03, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 3, 41, 1'b0, 8'hFE, 1'b0);
        vecs[3] = mk(8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1'b1, 8'hFE, 1'b0);
        vecs[4] = mk(8'h02, 8'h01, 8'h04, 8'h04, 8'h04, 8'h04, 6, 17, 1'b1, 8'h01, 1'b1);
        vecs[5] = mk(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1'b0, 8'h01, 1'b0);
        vecs[6] = mk(8'h01, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 2, 9, 1'b0, 8'h09, 1'b0);
        vecs[7] = mk(8'h03, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 3, 9, 1'b0, 8'h0A, 1'b0);
        vecs[8] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1'b1, 8'h0A, 1'b0);
        vecs[9] = mk(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1'b0, 8'h0A, 1'b0);

        bus.iRxData  = 8'h00;
        bus.iRxValid = 1'b0;
        iRst         = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        check("rst_ready", {31'd0, bus.oRxReady}, 0);
        check("rst_outputs", {bus.oSET_INDEX_FLAG, bus.oSET_CODE_FLAG, bus.oTrigger, oBusy,
                              oErr, oShadowIndex, bus.oSET_INDEX}, 0);
        check("rst_code", bus.oSET_CODE, 0);
        @(negedge iClk);
        iRst = 1'b0;
        @(posedge iClk); #1;
        check("rst_release_ready", {31'd0, bus.oRxReady}, 1);

        for (int i = 0; i < 10; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Next opcode presented during a WRITE waits out the whole sequence.
        v = mk(8'h02, 8'h21, 8'h12, 8'h34, 8'h56, 8'h78, 6, 17, 1'b0, 8'h21, 1'b0);
        push_model(v);
        v = mk(8'h01, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h00, 2, 9, 1'b0, 8'h2A, 1'b0);
        push_model(v);
        for (int i = 0; i < 6; i++)
            send_byte((i == 0) ? 8'h02 : ((i == 1) ? 8'h21 : 8'(8'h12 + 8'(34 * (i - 2)))),
                      1'b0, w);
        send_byte(8'h01, 1'b0, w);
        check("held_opcode_waits", w, 17);
        send_byte(8'h2A, 1'b0, w);
        finish_cmd("held_idx", v);

        // Reset during the second trigger of FIRE n=4.
        send_byte(8'h55, 1'b0, w);
        v = mk(8'h03, 8'h0C, 8'h01, 8'h00, 8'h00, 8'h00, 3, 0, 1'b1, 8'h0B, 1'b0);
        push_model(v);  // index pulse plus the one trigger that completes
        base = trig_falls;
        send_byte(8'h03, 1'b0, w);
        send_byte(8'h0C, 1'b0, w);
        send_byte(8'h04, 1'b0, w);
        lim = 0;
        forever begin
            @(negedge iClk);
            if ((trig_falls == base + 1 && bus.oTrigger) || lim > 500) break;
            lim++;
        end
        check("second_trigger_seen", {31'd0, bus.oTrigger}, 1);
        check("shadow_before_rst", {24'd0, oShadowIndex}, 8'h0B);
        iRst = 1'b1;
        @(posedge iClk); #1;
        check("midrst_trigger", {31'd0, bus.oTrigger}, 0);
        check("midrst_outputs", {bus.oSET_INDEX_FLAG, bus.oSET_CODE_FLAG, bus.oRxReady, oBusy,
                                 oErr, oShadowIndex, bus.oSET_INDEX}, 0);
        check("midrst_code", bus.oSET_CODE, 0);
        check("midrst_pending", exp_q.size(), 0);
        @(negedge iClk);
        iRst = 1'b0;
        @(posedge iClk); #1;
        check("midrst_release_ready", {31'd0, bus.oRxReady}, 1);
        v = mk(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 2, 9, 1'b0, 8'h03, 1'b0);
        run_vec("post_rst_idx", v);
        check("post_rst_triggers", trig_falls, base + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ext_code_loader.md
# ext_code_loader

Host-side sequencer that drives the 8-slot external-code table: it parses a byte-wide command stream and generates the set-index strobe, set-code strobe and trigger pulse trains that program and play back 32-bit codes. It sits between the host byte link and the external-code table. It is the writer/initiator end of the table's strobe interface. All strobes are regenerated in the iClk domain, with guaranteed data setup, pulse width and gap.

## Interface
- PULSE_W, 4, high width in cycles of each oSET_INDEX_FLAG / oSET_CODE_FLAG pulse (≥1)
- GAP_W, 4, minimum low cycles after each flag pulse (≥1)
- TRIG_HIGH, 8, oTrigger high cycles per trigger (≥1)
- TRIG_LOW, 8, oTrigger low cycles after each trigger (≥1)
- iClk  in  1  single clock; all logic on rising edge
- iRst  in  1  reset, synchronous, active-high
- iRxData  in  8  command/argument byte
- iRxValid  in  1  iRxData valid
- oRxReady  out  1  byte accepted on an edge where iRxValid & oRxReady
- oSET_INDEX_FLAG  out  1  index strobe to table
- oSET_INDEX  out  8  index value
- oSET_CODE_FLAG  out  1  code strobe to table
- oSET_CODE  out  32  code value
- oTrigger  out  1  playback trigger
- oBusy  out  1  sequence in progress (= ~oRxReady outside reset)
- oErr  out  1  sticky unknown-opcode flag
- oShadowIndex  out  8  model of the table's current index

## Operation
- Commands (first byte opcode, arguments follow, code bytes MSB first):
  - 0x01 IDX idx: one index pulse.
  - 0x02 WRITE idx c3 c2 c1 c0: index pulse, then code pulse with {c3,c2,c1,c0}.
  - 0x03 FIRE idx n: index pulse, then n triggers. n=0 gives the index pulse only.
  - 0x04 CLRERR: clears oErr; no strobes.
  - Any other opcode: byte dropped, oErr set, stay IDLE.
- States: IDLE, ARGS (collecting), SETUP, IDX_HI, IDX_GAP, CODE_HI, CODE_GAP, TRIG_HI, TRIG_LO.
- oRxReady=1 only in IDLE/ARGS and iRst=0. There is no timeout in ARGS; a partial command waits indefinitely.
- On the edge accepting the final argument:
  - oSET_INDEX, and oSET_CODE for WRITE, load.
  - State goes to SETUP.
  - These outputs then hold until the next command's final argument.
- Sequence after SETUP:
  - IDX_HI for PULSE_W cycles, then IDX_GAP for GAP_W cycles.
  - WRITE continues: CODE_HI for PULSE_W cycles, then CODE_GAP for GAP_W cycles.
  - FIRE continues: TRIG_HI for TRIG_HIGH cycles, then TRIG_LO for TRIG_LOW cycles, repeated n times; an 8-bit down-counter tracks the repeats.
  - Then return to IDLE.
- oSET_INDEX_FLAG, oSET_CODE_FLAG and oTrigger are registered, high exactly in IDX_HI, CODE_HI and TRIG_HI respectively. At most one is high at any time.
- oShadowIndex updates:
  - Loads idx on the cycle the index flag falls.
  - Decrements by 1, mod 256, on the cycle each trigger falls (0 → 255).
  - A code pulse leaves it unchanged.
- An 0x04 received mid-command is treated as an argument byte, not as an opcode.

## Timing
- Reset (iRst high at an edge): on that edge all outputs go to 0, including oErr and oShadowIndex, and the state goes to IDLE. oRxReady=0 while iRst is high and 1 the cycle after release.
- Reset mid-sequence aborts immediately: any high strobe drops on that edge and the partial command is discarded.
- Final argument accepted at edge E0:
  - E0: data outputs are valid, giving 1 cycle of setup.
  - E1: first flag rises.
  - Data is held for at least GAP_W cycles after the flag falls.
- Busy length counted from E0 to IDLE, with oRxReady high on the last edge:
  - IDX: 1+PULSE_W+GAP_W = 9.
  - WRITE: 1+2(PULSE_W+GAP_W) = 17.
  - FIRE: 9+n(TRIG_HIGH+TRIG_LOW) = 9+16n.
- Back-to-back commands: a new opcode can be accepted on the same edge that the state returns to IDLE. There are no idle cycles between commands beyond the gap states.
- oErr sets on the edge an unknown opcode is accepted and clears on the edge 0x04 is accepted.

## Test plan
- Reset, then WRITE 0x02 0x05 0xDE 0xAD 0xBE 0xEF ->
  - oSET_INDEX=5 one cycle before the index flag; index flag high 4 cycles, low 4.
  - oSET_CODE=0xDEADBEEF; code flag high 4 cycles.
  - oBusy for 17 cycles; oShadowIndex=5.
- FIRE 0x03 0x07 0x03 -> index pulse with idx 7, then 3 triggers (8 high / 8 low); oShadowIndex 7→6→5→4; busy 57 cycles.
- FIRE 0x03 0x00 0x02 -> oShadowIndex 0→255→254, showing wrap-around.
- Opcode 0x55 -> oErr=1, no strobes, oRxReady stays 1. Then 0x04 -> oErr=0.
- iRst asserted during the second trigger of FIRE n=4 -> oTrigger=0 on that edge, all outputs 0. After release, IDX 0x01 0x03 runs normally.
- iRxValid toggled randomly during WRITE argument bytes -> bytes accepted only on handshake. With oRxReady=0 during the sequence, no bytes are consumed; the next command byte is accepted on the return to IDLE.
